// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one combinational single-precision divider between
// two requesters. Round-robin accept, two register stages around the divider,
// and a small result FIFO per port. Per-port credits (out_cnt) bound the work
// in flight so the pipeline never has to stall and a result is never dropped.

// DIV: combinational single-precision divider. Normal operands give a
// truncated quotient; zero, infinite and NaN operands map to simple
// canonical results.
module DIV (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  logic              sign;
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [47:0]       num;
  logic [47:0]       den;
  logic [24:0]       quo;
  logic signed [9:0] exp_raw;
  logic signed [9:0] exp_adj;
  logic [22:0]       frac;

  // Mantissa ratio lies in (0.5, 2), so the quotient needs at most one
  // normalisation shift; the exponent drops by one when the ratio is below 1.
  always_comb begin
    sign    = a[31] ^ b[31];
    ea      = a[30:23];
    eb      = b[30:23];
    num     = {1'b1, a[22:0], 24'd0};
    den     = {24'd0, 1'b1, b[22:0]};
    quo     = 25'(num / den);
    exp_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    if (quo[24]) begin
      frac    = quo[23:1];
      exp_adj = exp_raw;
    end else begin
      frac    = quo[22:0];
      exp_adj = exp_raw - 10'sd1;
    end
    q = {sign, exp_adj[7:0], frac};
    if (ea == 8'hFF || eb == 8'hFF || (ea == 8'd0 && eb == 8'd0)) begin
      q = 32'h7FC0_0000;
    end else if (eb == 8'd0) begin
      q = {sign, 8'hFF, 23'd0};
    end else if (ea == 8'd0) begin
      q = {sign, 31'd0};
    end else if (exp_adj >= 10'sd255) begin
      q = {sign, 8'hFF, 23'd0};
    end else if (exp_adj <= 10'sd0) begin
      q = {sign, 31'd0};
    end
  end
endmodule

// DATA_WIDTH must stay 32 to match DIV; FIFO_DEPTH may be 1..4.
module fp_div_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_q,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_q,
  output logic                  busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [1:0]            req_valid;
  logic [1:0]            rsp_ready;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic [1:0]            pop;
  logic [1:0]            push;
  logic [1:0]            not_empty;
  logic [1:0]            full;
  logic                  prio;
  logic [CW-1:0]         out_cnt  [2];
  logic [CW-1:0]         fifo_cnt [2];
  logic [PW-1:0]         wr_ptr   [2];
  logic [PW-1:0]         rd_ptr   [2];
  logic [DATA_WIDTH-1:0] fifo_mem [2][FIFO_DEPTH];

  logic                  v1;
  logic                  tag1;
  logic [DATA_WIDTH-1:0] a1;
  logic [DATA_WIDTH-1:0] b1;
  logic                  v2;
  logic                  tag2;
  logic [DATA_WIDTH-1:0] q2;
  logic [DATA_WIDTH-1:0] div_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Eligibility from credits, FIFO status, and the round-robin grant.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i]      = req_valid[i] && (out_cnt[i] < DEPTH_C);
      not_empty[i] = (fifo_cnt[i] != '0);
      full[i]      = (fifo_cnt[i] == DEPTH_C);
      pop[i]       = not_empty[i] && rsp_ready[i];
    end
    push[0] = v2 && !tag2;
    push[1] = v2 && tag2;
    grant   = elig;
    if (elig == 2'b11) begin
      grant       = 2'b00;
      grant[prio] = 1'b1;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = not_empty[0];
  assign rsp1_valid = not_empty[1];
  assign rsp0_q     = fifo_mem[0][rd_ptr[0]];
  assign rsp1_q     = fifo_mem[1][rd_ptr[1]];
  assign busy       = v1 || v2 || (|not_empty);

  DIV u_div (
    .a (a1),
    .b (b1),
    .q (div_q)
  );

  // Control state: priority pointer, stage valids, credits and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        out_cnt[i]  <= '0;
        fifo_cnt[i] <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
      end
    end else begin
      if (|grant) begin
        prio <= grant[0];
      end
      v1 <= |grant;
      v2 <= v1;
      for (int i = 0; i < 2; i++) begin
        if (grant[i] && !pop[i]) begin
          out_cnt[i] <= out_cnt[i] + CW'(1);
        end else if (!grant[i] && pop[i]) begin
          out_cnt[i] <= out_cnt[i] - CW'(1);
        end
        if (push[i] && !pop[i]) begin
          fifo_cnt[i] <= fifo_cnt[i] + CW'(1);
        end else if (!push[i] && pop[i]) begin
          fifo_cnt[i] <= fifo_cnt[i] - CW'(1);
        end
        if (push[i]) begin
          wr_ptr[i] <= ptr_next(wr_ptr[i]);
        end
        if (pop[i]) begin
          rd_ptr[i] <= ptr_next(rd_ptr[i]);
        end
      end
    end
  end

  // Datapath registers and FIFO storage; contents are only meaningful
  // alongside their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    tag1 <= grant[1];
    a1   <= grant[1] ? req1_a : req0_a;
    b1   <= grant[1] ? req1_b : req0_b;
    tag2 <= tag1;
    q2   <= div_q;
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        fifo_mem[i][wr_ptr[i]] <= q2;
      end
    end
  end

  // Credits must make a push onto a full FIFO impossible unless it pops too.
  assert property (@(posedge clk) disable iff (rst) !(v2 && full[tag2] && !pop[tag2]));

endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed and random checks of the shared divider
// arbiter using a table of operand pairs with exactly representable quotients.
module tb_fp_div_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_q, rsp1_q;
  logic [2:0]  idx0, idx1;

  int errors = 0;
  int checks = 0;

  logic        acc0, acc1, pop0, pop1, rdy0_s, rdy1_s, rv0_s, rv1_s, busy_s;
  logic        miss0, miss1;
  logic [31:0] q0_s, q1_s, want0, want1;
  logic [31:0] sb0 [$];
  logic [31:0] sb1 [$];
  int          cnt0, cnt1, npop0, npop1;

  always #5 clk = ~clk;

  fp_div_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_q     (rsp0_q),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_q     (rsp1_q),
    .busy       (busy)
  );

  // Operand table: dividend, divisor and hand-computed exact quotient.
  function automatic logic [31:0] op_a(input logic [2:0] i);
    case (i)
      3'd0: return 32'h40C0_0000;
      3'd1: return 32'h3F80_0000;
      3'd2: return 32'h4090_0000;
      3'd3: return 32'hC0C0_0000;
      3'd4: return 32'h4120_0000;
      3'd5: return 32'h42C8_0000;
      3'd6: return 32'h3F80_0000;
      default: return 32'h3FC0_0000;
    endcase
  endfunction

  function automatic logic [31:0] op_b(input logic [2:0] i);
    case (i)
      3'd0: return 32'h4000_0000;
      3'd1: return 32'h4000_0000;
      3'd2: return 32'h3FC0_0000;
      3'd3: return 32'h4000_0000;
      3'd4: return 32'h40A0_0000;
      3'd5: return 32'hC120_0000;
      3'd6: return 32'h4100_0000;
      default: return 32'h4040_0000;
    endcase
  endfunction

  function automatic logic [31:0] op_q(input logic [2:0] i);
    case (i)
      3'd0: return 32'h4040_0000;
      3'd1: return 32'h3F00_0000;
      3'd2: return 32'h4040_0000;
      3'd3: return 32'hC040_0000;
      3'd4: return 32'h4000_0000;
      3'd5: return 32'hC120_0000;
      3'd6: return 32'h3E00_0000;
      default: return 32'h3F00_0000;
    endcase
  endfunction

  assign req0_a = op_a(idx0);
  assign req0_b = op_b(idx0);
  assign req1_a = op_a(idx1);
  assign req1_b = op_b(idx1);

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    idx0 = 3'd0; idx1 = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb0.delete(); sb1.delete();
    cnt0 = 0; cnt1 = 0; npop0 = 0; npop1 = 0;
  endtask

  // Samples one cycle at the falling edge and keeps the expected-result
  // queues and outstanding counts up to date; returns just after the rising edge.
  task automatic clock_cycle();
    @(negedge clk);
    rdy0_s = req0_ready; rdy1_s = req1_ready;
    rv0_s = rsp0_valid;  rv1_s = rsp1_valid;
    q0_s = rsp0_q;       q1_s = rsp1_q;
    busy_s = busy;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    pop0 = rsp0_valid && rsp0_ready;
    pop1 = rsp1_valid && rsp1_ready;
    miss0 = 1'b0; miss1 = 1'b0;
    if (pop0) begin
      npop0++; cnt0--;
      if (sb0.size() > 0) want0 = sb0.pop_front(); else begin want0 = 'x; miss0 = 1'b1; end
    end
    if (pop1) begin
      npop1++; cnt1--;
      if (sb1.size() > 0) want1 = sb1.pop_front(); else begin want1 = 'x; miss1 = 1'b1; end
    end
    if (acc0) begin sb0.push_back(op_q(idx0)); cnt0++; end
    if (acc1) begin sb1.push_back(op_q(idx1)); cnt1++; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    idx0 = 3'd0; idx1 = 3'd0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp0_valid got=%b want=0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp1_valid got=%b want=0", rsp1_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_ready got=%b want=0", req0_ready); end
    req0_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req0_eligible got=%b want=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_ready got=%b want=0", req1_ready); end
    req0_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    idx0 = 3'd0; req0_valid = 1'b1; rsp0_ready = 1'b1;
    clock_cycle();
    checks++; if (rdy0_s !== 1'b1) begin errors++; $display("[TB] FAIL single_accept got=%b want=1", rdy0_s); end
    req0_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      clock_cycle();
      checks++;
      if (rv0_s !== (n == 3)) begin errors++; $display("[TB] FAIL single_rsp_valid cycle=%0d got=%b want=%b", n, rv0_s, (n == 3)); end
      if (n == 1) begin
        checks++; if (busy_s !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_high got=%b want=1", busy_s); end
      end
      if (n == 3) begin
        checks++; if (q0_s !== 32'h4040_0000) begin errors++; $display("[TB] FAIL single_q got=%h want=40400000", q0_s); end
      end
      if (n == 4) begin
        checks++; if (busy_s !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_drop got=%b want=0", busy_s); end
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      req0_valid = (n < 8); req1_valid = (n < 8);
      idx0 = 3'(n); idx1 = 3'(n + 3);
      clock_cycle();
      if (n < 8) begin
        checks++; if (rdy0_s !== (n % 2 == 0)) begin errors++; $display("[TB] FAIL contention_grant0 cycle=%0d got=%b want=%b", n, rdy0_s, (n % 2 == 0)); end
        checks++; if (rdy1_s !== (n % 2 == 1)) begin errors++; $display("[TB] FAIL contention_grant1 cycle=%0d got=%b want=%b", n, rdy1_s, (n % 2 == 1)); end
      end
      if (pop0) begin checks++; if (miss0 || q0_s !== want0) begin errors++; $display("[TB] FAIL contention_q0 got=%h want=%h", q0_s, want0); end end
      if (pop1) begin checks++; if (miss1 || q1_s !== want1) begin errors++; $display("[TB] FAIL contention_q1 got=%h want=%h", q1_s, want1); end end
    end
    checks++; if (npop0 != 4) begin errors++; $display("[TB] FAIL contention_count0 got=%0d want=4", npop0); end
    checks++; if (npop1 != 4) begin errors++; $display("[TB] FAIL contention_count1 got=%0d want=4", npop1); end
  endtask

  task automatic test_backpressure();
    int acc0n = 0;
    int acc1n = 0;
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      idx0 = 3'(n); idx1 = 3'(n + 5);
      clock_cycle();
      if (acc0) acc0n++;
      if (acc1) acc1n++;
      checks++; if (rdy1_s !== (n == 1 || n == 3)) begin errors++; $display("[TB] FAIL bp_ready1 cycle=%0d got=%b want=%b", n, rdy1_s, (n == 1 || n == 3)); end
      if (pop0) begin checks++; if (miss0 || q0_s !== want0) begin errors++; $display("[TB] FAIL bp_q0 got=%h want=%h", q0_s, want0); end end
    end
    checks++; if (acc1n != 2) begin errors++; $display("[TB] FAIL bp_accepts1 got=%0d want=2", acc1n); end
    checks++; if (acc0n != 6) begin errors++; $display("[TB] FAIL bp_accepts0 got=%0d want=6", acc0n); end
    req0_valid = 1'b0; rsp1_ready = 1'b1; idx1 = 3'd6;
    for (int d = 0; d < 8; d++) begin
      req1_valid = (d < 2);
      clock_cycle();
      if (d < 2) begin
        checks++; if (rdy1_s !== (d == 1)) begin errors++; $display("[TB] FAIL bp_resume cycle=%0d got=%b want=%b", d, rdy1_s, (d == 1)); end
      end
      if (pop0) begin checks++; if (miss0 || q0_s !== want0) begin errors++; $display("[TB] FAIL bp_q0 got=%h want=%h", q0_s, want0); end end
      if (pop1) begin checks++; if (miss1 || q1_s !== want1) begin errors++; $display("[TB] FAIL bp_q1 got=%h want=%h", q1_s, want1); end end
    end
    checks++; if (npop1 != 3) begin errors++; $display("[TB] FAIL bp_drain1 got=%0d want=3", npop1); end
    checks++; if (sb0.size() != 0) begin errors++; $display("[TB] FAIL bp_left0 got=%0d want=0", sb0.size()); end
  endtask

  task automatic test_accept_pop();
    int accn = 0;
    do_reset();
    req0_valid = 1'b1; rsp0_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      idx0 = 3'(n);
      clock_cycle();
      if (acc0) accn++;
      checks++; if (rdy0_s !== (n < 2)) begin errors++; $display("[TB] FAIL ap_fill cycle=%0d got=%b want=%b", n, rdy0_s, (n < 2)); end
    end
    rsp0_ready = 1'b1; idx0 = 3'd5;
    for (int n = 0; n < 2; n++) begin
      clock_cycle();
      if (acc0) accn++;
      checks++; if (rdy0_s !== (n == 1)) begin errors++; $display("[TB] FAIL ap_grant_after_pop cycle=%0d got=%b want=%b", n, rdy0_s, (n == 1)); end
      if (pop0) begin checks++; if (miss0 || q0_s !== want0) begin errors++; $display("[TB] FAIL ap_q0 got=%h want=%h", q0_s, want0); end end
    end
    for (int n = 0; n < 12; n++) begin
      req0_valid = (n < 8);
      idx0 = 3'(n + 6);
      clock_cycle();
      if (acc0) accn++;
      checks++; if (cnt0 > 2) begin errors++; $display("[TB] FAIL ap_outstanding got=%0d want<=2", cnt0); end
      if (pop0) begin checks++; if (miss0 || q0_s !== want0) begin errors++; $display("[TB] FAIL ap_q0 got=%h want=%h", q0_s, want0); end end
    end
    checks++; if (npop0 != accn || accn < 6) begin errors++; $display("[TB] FAIL ap_wrap_count got=%0d want=%0d (>=6)", npop0, accn); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      idx0 = 3'(n); idx1 = 3'(n + 4);
      clock_cycle();
    end
    checks++; if ((rsp0_valid && rsp1_valid && busy) !== 1'b1) begin errors++; $display("[TB] FAIL mid_preload got=%b%b%b want=111", rsp0_valid, rsp1_valid, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rsp0_valid got=%b want=0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rsp1_valid got=%b want=0", rsp1_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL mid_prio got=%b want=01", {req1_ready, req0_ready}); end
    @(posedge clk);
    #1 rst = 1'b0;
    sb0.delete(); sb1.delete(); cnt0 = 0; cnt1 = 0; npop0 = 0; npop1 = 0;
    idx0 = 3'd2; idx1 = 3'd5;
    clock_cycle();
    checks++; if ({rdy1_s, rdy0_s} !== 2'b01) begin errors++; $display("[TB] FAIL mid_first_grant got=%b want=01", {rdy1_s, rdy0_s}); end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      clock_cycle();
      checks++; if (rv0_s !== (n == 3)) begin errors++; $display("[TB] FAIL mid_rsp0_valid cycle=%0d got=%b want=%b", n, rv0_s, (n == 3)); end
      checks++; if (rv1_s !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale1 cycle=%0d got=%b want=0", n, rv1_s); end
      if (n == 3) begin
        checks++; if (q0_s !== 32'h4040_0000) begin errors++; $display("[TB] FAIL mid_q0 got=%h want=40400000", q0_s); end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 10010; n++) begin
      if (n < 10000) begin
        req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
        rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
        idx0 = 3'($urandom_range(0, 7)); idx1 = 3'($urandom_range(0, 7));
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      end
      clock_cycle();
      checks++; if (cnt0 > 2 || cnt1 > 2) begin errors++; $display("[TB] FAIL rand_outstanding got=%0d/%0d want<=2", cnt0, cnt1); end
      if (pop0) begin checks++; if (miss0 || q0_s !== want0) begin errors++; $display("[TB] FAIL rand_q0 cycle=%0d got=%h want=%h", n, q0_s, want0); end end
      if (pop1) begin checks++; if (miss1 || q1_s !== want1) begin errors++; $display("[TB] FAIL rand_q1 cycle=%0d got=%h want=%h", n, q1_s, want1); end end
    end
    checks++; if (sb0.size() != 0 || sb1.size() != 0) begin errors++; $display("[TB] FAIL rand_drops got=%0d/%0d want=0/0", sb0.size(), sb1.size()); end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_accept_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guards against a run that never reaches the summary.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
